univ_shift_reg_burst: RTL

Parametrised universal shift register. It generalises the fixed 4-bit hold/shift-right/shift-left/load register to WIDTH bits and eight modes, adding rotate and arithmetic shift. It also adds a burst engine that repeats one operation a programmed number of times with a busy/done handshake. It is a datapath leaf used for serialisers and bit-manipulation paths. One clock, no CDC.

---
 rtl/univ_shift_reg_burst.sv | 90 +++++++++
 1 files changed

// File: rtl/univ_shift_reg_burst.sv
// univ_shift_reg_burst: WIDTH-bit universal shift register with eight modes and a counted burst engine
module univ_shift_reg_burst #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] p,
  input  logic             sr,
  input  logic             sl,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, op_val;
  logic [2:0]       mode_q, mode_d, op_mode;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  // one operation on the current contents; a running burst uses its latched mode
  always_comb begin
    op_mode = (state_q == BURST) ? mode_q : s;
    op_val  = q_q;
    case (op_mode)
      3'b001:  op_val = {sr, q_q[WIDTH-1:1]};
      3'b010:  op_val = {q_q[WIDTH-2:0], sl};
      3'b011:  op_val = p;
      3'b100:  op_val = {q_q[0], q_q[WIDTH-1:1]};
      3'b101:  op_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      3'b110:  op_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      default: op_val = q_q;
    endcase
  end
  // burst sequencing: start wins over en, and the first burst operation happens on the start edge
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == BURST) begin
      q_d   = op_val;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (start) begin
      mode_d = s;
      cnt_d  = (amt == '0) ? '0 : amt - 1'b1;
      if (amt == '0) begin
        done_d = 1'b1;
      end else begin
        q_d = op_val;
        if (amt == CNT_W'(1)) done_d = 1'b1;
        else state_d = BURST;
      end
    end else if (en) begin
      q_d = op_val;
    end
  end
  // state registers with asynchronous active-low clear that also aborts a burst
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign busy = (state_q == BURST);
  assign done = done_q;
endmodule
